// File: rtl/maze_pkg.sv
// Shared maze geometry, direction encoding and query FSM states.
// Used by the query block and the player movement logic.
package maze_pkg;

    localparam int MAZE_W = 28;
    localparam int MAZE_H = 31;
    localparam int X_W    = 5;
    localparam int Y_W    = 5;
    localparam int ADDR_W = 10;

    // Same encoding as the ghost dirToMove output.
    typedef enum logic [1:0] {
        UP    = 2'd0,
        RIGHT = 2'd1,
        DOWN  = 2'd2,
        LEFT  = 2'd3
    } dir_t;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        RD_U   = 3'd1,
        RD_R   = 3'd2,
        RD_D   = 3'd3,
        RD_L   = 3'd4,
        CAPT_L = 3'd5,
        DONE   = 3'd6
    } query_state_t;

    function automatic logic [ADDR_W-1:0] tile_addr(input logic [X_W-1:0] x,
                                                    input logic [Y_W-1:0] y);
        return ADDR_W'(y) * ADDR_W'(MAZE_W) + ADDR_W'(x);
    endfunction

endpackage

// File: rtl/maze_neighbor_addr.sv
// Combinational neighbour-tile address: horizontal moves wrap through the
// tunnel, vertical moves off the maze are blocked and point at the centre tile.
module maze_neighbor_addr
    import maze_pkg::*;
(
    input  logic [X_W-1:0]    x,
    input  logic [Y_W-1:0]    y,
    input  dir_t              dir,
    output logic [ADDR_W-1:0] addr,
    output logic              blocked
);

    logic [X_W-1:0] nx;
    logic [Y_W-1:0] ny;

    always_comb begin
        nx      = x;
        ny      = y;
        blocked = 1'b0;
        case (dir)
            UP: begin
                if (y == Y_W'(0)) blocked = 1'b1;
                else              ny = y - Y_W'(1);
            end
            DOWN: begin
                if (y == Y_W'(MAZE_H - 1)) blocked = 1'b1;
                else                       ny = y + Y_W'(1);
            end
            LEFT:  nx = (x == X_W'(0)) ? X_W'(MAZE_W - 1) : x - X_W'(1);
            RIGHT: nx = (x == X_W'(MAZE_W - 1)) ? X_W'(0) : x + X_W'(1);
            default: ;
        endcase
        addr = tile_addr(nx, ny);
    end

endmodule

// File: rtl/maze_move_query.sv
// Reads the four neighbours of a tile from the maze wall RAM (one per cycle)
// and reports which directions are open, with a one-cycle done pulse.
module maze_move_query
    import maze_pkg::*;
(
    input  logic              clk,
    input  logic              reset,
    input  logic              req,
    input  logic [X_W-1:0]    posX,
    input  logic [Y_W-1:0]    posY,
    output logic              busy,
    output logic              done,
    output logic              canMoveU,
    output logic              canMoveR,
    output logic              canMoveD,
    output logic              canMoveL,
    output logic              mem_rd_en,
    output logic [ADDR_W-1:0] mem_addr,
    input  logic              mem_wall
);

    query_state_t      state_q, state_d;
    logic [X_W-1:0]    x_q;
    logic [Y_W-1:0]    y_q;
    logic              blk_q;
    logic              sh_u_q, sh_r_q, sh_d_q;
    logic              can_u_q, can_r_q, can_d_q, can_l_q;
    logic              open_prev;
    dir_t              rd_dir;
    logic [ADDR_W-1:0] nb_addr;
    logic              nb_blocked;

    maze_neighbor_addr u_nb (
        .x       (x_q),
        .y       (y_q),
        .dir     (rd_dir),
        .addr    (nb_addr),
        .blocked (nb_blocked)
    );

    always_ff @(posedge clk) begin
        if (reset) state_q <= IDLE;
        else       state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (req) state_d = RD_U;
            RD_U:    state_d = RD_R;
            RD_R:    state_d = RD_D;
            RD_D:    state_d = RD_L;
            RD_L:    state_d = CAPT_L;
            CAPT_L:  state_d = DONE;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        rd_dir    = UP;
        mem_rd_en = 1'b0;
        case (state_q)
            RD_U: begin rd_dir = UP;    mem_rd_en = 1'b1; end
            RD_R: begin rd_dir = RIGHT; mem_rd_en = 1'b1; end
            RD_D: begin rd_dir = DOWN;  mem_rd_en = 1'b1; end
            RD_L: begin rd_dir = LEFT;  mem_rd_en = 1'b1; end
            default: ;
        endcase
        mem_addr = mem_rd_en ? nb_addr : '0;
        busy     = (state_q != IDLE);
        done     = (state_q == DONE);
    end

    // Read data arriving now belongs to the slot issued last cycle; blk_q
    // remembers whether that slot was an off-maze (blocked) direction.
    assign open_prev = ~mem_wall & ~blk_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            x_q     <= '0;
            y_q     <= '0;
            blk_q   <= 1'b0;
            sh_u_q  <= 1'b0;
            sh_r_q  <= 1'b0;
            sh_d_q  <= 1'b0;
            can_u_q <= 1'b0;
            can_r_q <= 1'b0;
            can_d_q <= 1'b0;
            can_l_q <= 1'b0;
        end else begin
            if (state_q == IDLE && req) begin
                x_q <= posX;
                y_q <= posY;
            end
            if (mem_rd_en) blk_q <= nb_blocked;
            case (state_q)
                RD_R: sh_u_q <= open_prev;
                RD_D: sh_r_q <= open_prev;
                RD_L: sh_d_q <= open_prev;
                // LEFT result lands on the same edge as the flag update.
                CAPT_L: begin
                    can_u_q <= sh_u_q;
                    can_r_q <= sh_r_q;
                    can_d_q <= sh_d_q;
                    can_l_q <= open_prev;
                end
                default: ;
            endcase
        end
    end

    assign canMoveU = can_u_q;
    assign canMoveR = can_r_q;
    assign canMoveD = can_d_q;
    assign canMoveL = can_l_q;

endmodule

// File: doc/maze_move_query.md
# maze_move_query

Answers "which directions are open from tile (X,Y)?" for the ghost and player movement logic. On a request it latches a tile coordinate and reads the four neighbouring tiles from the synchronous maze wall memory, one per cycle. It then returns the canMoveU/R/D/L flags that the ghost direction logic consumes, with a one-cycle done pulse. It is the maze-side responder to the direction chooser and sits between the movement controllers and the maze tile RAM.

## Interface
- MAZE_W, 28, maze width in tiles
- MAZE_H, 31, maze height in tiles
- X_W, 5, X coordinate width
- Y_W, 5, Y coordinate width
- ADDR_W, 10, maze memory address width; address = y*MAZE_W + x
- clk  input  1  single clock; all logic on posedge
- reset  input  1  synchronous, active-high
- req  input  1  start query; sampled only in IDLE
- posX  input  X_W  tile X to query; latched with req
- posY  input  Y_W  tile Y to query; latched with req
- busy  output  1  high from the cycle after acceptance through the DONE cycle
- done  output  1  one-cycle pulse; flags valid from this cycle on
- canMoveU, canMoveR, canMoveD, canMoveL  output  1 each  1 = neighbour is open floor
- mem_rd_en  output  1  maze memory read strobe
- mem_addr  output  ADDR_W  maze memory address
- mem_wall  input  1  memory read data, 1 = wall; valid the cycle after mem_rd_en

## Operation
- States: IDLE, RD_U, RD_R, RD_D, RD_L, CAPT_L, DONE.
- IDLE with req=1: latch posX/posY, go to RD_U. req in any other state is ignored and is not queued.
- RD_U/RD_R/RD_D/RD_L: mem_rd_en=1, mem_addr = that neighbour's address. Each state captures mem_wall for the previous direction into a shadow register.
- CAPT_L: mem_rd_en=0; capture the LEFT result.
- On the edge into DONE, all four output flags load together from the shadow registers. DONE lasts one cycle (done=1), then the FSM returns to IDLE.
- Flags hold their value until the next DONE.
- Neighbour rules:
  - UP: (x, y-1). At y=0 the direction is blocked: flag forced to 0, no wrap.
  - DOWN: (x, y+1). At y=MAZE_H-1 the direction is blocked: flag forced to 0.
  - LEFT: (x-1, y). At x=0 it wraps to MAZE_W-1 (tunnel).
  - RIGHT: (x+1, y). At x=MAZE_W-1 it wraps to 0 (tunnel).
- A blocked direction still occupies its read slot, so latency is fixed. During that slot mem_addr = the centre tile address and the returned data is discarded.
- Flag = ~mem_wall for non-blocked directions.
- Address arithmetic is unsigned, computed at ADDR_W bits with no truncation. Inputs with posX ≥ MAZE_W or posY ≥ MAZE_H are out of contract.

## Timing
- req sampled in cycle 0 → RD_U in cycle 1 … CAPT_L in cycle 5 → done=1 in cycle 6. Fixed 6-cycle latency.
- Back-to-back: the earliest next acceptance is the cycle after DONE (cycle 7), giving 7-cycle throughput.
- busy=1 in cycles 1–6 and 0 in IDLE.
- Memory contract: read latency is exactly 1 cycle. mem_wall for the address issued in cycle n is sampled at the end of cycle n+1.
- Reset values, including reset mid-query: state=IDLE, busy=0, done=0, all canMove*=0, mem_rd_en=0, mem_addr=0. Any query in progress is dropped with no done pulse.
- req asserted together with reset is ignored.

## Structure
- Shared package maze_pkg holds:
  - MAZE_W, MAZE_H and the derived widths
  - dir_t enum: UP=2'd0, RIGHT=2'd1, DOWN=2'd2, LEFT=2'd3 (same encoding as the ghost dirToMove output)
  - query FSM state enum
- One sub-module, maze_neighbor_addr (combinational): inputs x, y, dir_t; outputs address and blocked. It applies the wrap and edge rules above. It is reused by the player movement block.

## Test plan
- Open centre tile: memory all-zero, req at (10,10) in cycle 0 → done in cycle 6 with U=R=D=L=1. mem_addr sequence 262, 291, 318, 289.
- Walls: memory walls at (10,9) and (9,10), req at (10,10) → U=0, R=1, D=1, L=0. Flags hold after done until the next done.
- Tunnel wrap: req at (0,14) with (27,14) open and (1,14) wall → LEFT read address 419, L=1, R=0. Then req at (27,14) → RIGHT read address 392.
- Edge block: req at (5,0) with memory all-zero → U=0 and UP slot mem_addr=5. Req at (5,30) → D=0.
- Protocol: req held high continuously → accepted in cycles 0, 7, 14. Reqs during busy are ignored. Exactly one done pulse per accepted req.
- Reset mid-query: reset in cycle 3 → next cycle busy=0, done=0, flags=0. No done pulse appears. A new req after reset completes normally with 6-cycle latency.
